// File: rtl/operand_loader_pkg.sv
// Shared operand-path definitions: default widths and the loader FSM encoding,
// also used by the operand register file and the operand B loader.
package operand_loader_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BUS_WIDTH_DEF  = 64;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int MAX_DIM_DEF    = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ROW = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } load_state_t;

  // Width of a dimension field able to hold 0..max_dim inclusive.
  function automatic int dim_width(input int max_dim);
    return $clog2(max_dim + 1);
  endfunction

endpackage

// File: rtl/operand_loader_row_serializer.sv
// Row buffer plus column counter: holds one accepted bus row and presents the
// element for the next column still to be written.
module row_serializer
  import operand_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int MAX_DIM    = MAX_DIM_DEF,
  parameter int DIM_W      = dim_width(MAX_DIM)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load,
  input  logic                  step,
  input  logic [BUS_WIDTH-1:0]  row,
  input  logic [DIM_W-1:0]      dim_m,
  output logic [DATA_WIDTH-1:0] elem,
  output logic [DIM_W-1:0]      col,
  output logic                  more
);

  logic [BUS_WIDTH-1:0]  row_reg;
  logic [DIM_W-1:0]      col_reg;
  logic [DATA_WIDTH-1:0] elems [MAX_DIM];

  // Column 0 is written straight from the bus on the accepting edge, so the
  // counter resumes at column 1.
  always_ff @(posedge clk) begin
    if (srst) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (load) begin
      row_reg <= row;
      col_reg <= DIM_W'(1);
    end else if (step && more) begin
      col_reg <= col_reg + DIM_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_elem
      assign elems[gi] = row_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    elem = '0;
    for (int i = 0; i < MAX_DIM; i++) begin
      if (col_reg == DIM_W'(i)) elem = elems[i];
    end
  end

  assign col  = col_reg;
  assign more = (col_reg < dim_m);

endmodule

// File: rtl/operand_loader.sv
// Loads one dim_n x dim_m operand matrix, one bus row at a time, into the
// operand register file as individual element writes at row*MAX_DIM+col.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int DIM_W     = dim_width(MAX_DIM)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      dim_n_i,
  input  logic [DIM_W-1:0]      dim_m_i,
  input  logic                  bus_valid_i,
  input  logic [BUS_WIDTH-1:0]  bus_data_i,
  output logic                  bus_ready_o,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  load_state_t           state_reg;
  logic [DIM_W-1:0]      dim_n_reg;
  logic [DIM_W-1:0]      dim_m_reg;
  logic [DIM_W-1:0]      row_reg;
  logic                  ready_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic                  dims_ok;
  logic                  accept;
  logic                  ser_step;
  logic [DATA_WIDTH-1:0] ser_elem;
  logic [DIM_W-1:0]      ser_col;
  logic                  ser_more;
  logic [DIM_W-1:0]      row_inc;

  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [DIM_W-1:0] r,
                                                      input logic [DIM_W-1:0] c);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(c);
  endfunction

  assign dims_ok  = (dim_n_i != '0) && (dim_n_i <= DIM_W'(MAX_DIM)) &&
                    (dim_m_i != '0) && (dim_m_i <= DIM_W'(MAX_DIM));
  assign accept   = (state_reg == ST_WAIT_ROW) && bus_valid_i && ready_reg;
  assign ser_step = (state_reg == ST_WRITE) && ser_more;
  assign row_inc  = row_reg + DIM_W'(1);

  row_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH),
    .MAX_DIM   (MAX_DIM),
    .DIM_W     (DIM_W)
  ) u_row_serializer (
    .clk  (clk),
    .srst (rst_i),
    .load (accept),
    .step (ser_step),
    .row  (bus_data_i),
    .dim_m(dim_m_reg),
    .elem (ser_elem),
    .col  (ser_col),
    .more (ser_more)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      dim_n_reg <= '0;
      dim_m_reg <= '0;
      row_reg   <= '0;
      ready_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      // Write port and pulses default to idle so addr/data read 0 without a write.
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            if (dims_ok) begin
              dim_n_reg <= dim_n_i;
              dim_m_reg <= dim_m_i;
              row_reg   <= '0;
              ready_reg <= 1'b1;
              busy_reg  <= 1'b1;
              state_reg <= ST_WAIT_ROW;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_WAIT_ROW: begin
          if (accept) begin
            we_reg    <= 1'b1;
            addr_reg  <= elem_addr(row_reg, '0);
            wdata_reg <= bus_data_i[DATA_WIDTH-1:0];
            ready_reg <= 1'b0;
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ser_more) begin
            we_reg    <= 1'b1;
            addr_reg  <= elem_addr(row_reg, ser_col);
            wdata_reg <= ser_elem;
          end else if (row_inc < dim_n_reg) begin
            row_reg   <= row_inc;
            ready_reg <= 1'b1;
            state_reg <= ST_WAIT_ROW;
          end else begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_ready_o = ready_reg;
  assign rf_we_o     = we_reg;
  assign rf_addr_o   = addr_reg;
  assign rf_wdata_o  = wdata_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one matrix element.
REQ-002 SHALL have parameter BUS_WIDTH, default 64, width of one input bus word, which carries one matrix row.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, width of the register-file address.
REQ-004 SHALL have parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH, the maximum rows and columns.
REQ-005 SHALL use DIM_W = clog2(MAX_DIM+1) for dimension fields.
REQ-006 SHALL have ports, one clock, reset synchronous active-high:
- clk  in  1  sole clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin loading one operand matrix.
- dim_n_i  in  DIM_W  row count; sampled with start_i.
- dim_m_i  in  DIM_W  column count; sampled with start_i.
- bus_valid_i  in  1  bus_data_i holds a row.
- bus_data_i  in  BUS_WIDTH  row; element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- bus_ready_o  out  1  loader accepts a row this cycle.
- rf_we_o  out  1  register-file write enable.
- rf_addr_o  out  ADDR_WIDTH  element address = row*MAX_DIM + col.
- rf_wdata_o  out  DATA_WIDTH  element data.
- busy_o  out  1  load in progress (any state except IDLE).
- done_o  out  1  one-cycle pulse, load complete.
- err_o  out  1  one-cycle pulse, start rejected.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_ROW, WRITE, DONE.
REQ-008 IDLE: start_i with 1<=dim_n_i<=MAX_DIM and 1<=dim_m_i<=MAX_DIM SHALL latch the dims, clear the row/col counters, and go to WAIT_ROW next cycle.
REQ-009 IDLE: start_i with either dim 0 or >MAX_DIM SHALL pulse err_o the next cycle, stay IDLE, and cause no writes.
REQ-010 bus_ready_o SHALL be 1 only in WAIT_ROW; a row is accepted on an edge where bus_valid_i&&bus_ready_o, and is captured into a row buffer, moving the FSM to WRITE.
REQ-011 WRITE SHALL issue exactly dim_m writes on consecutive cycles, col 0..dim_m-1, with rf_wdata_o = buffered element col; the first write occurs in the cycle after acceptance.
REQ-012 Columns >= dim_m SHALL never be written; bus bits above dim_m elements are ignored.
REQ-013 After the last column, SHALL go to WAIT_ROW if row < dim_n-1 (row incremented), else DONE.
REQ-014 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE; done_o is 1 in the cycle after the final write.
REQ-015 start_i SHALL be ignored whenever busy_o=1.
REQ-016 bus_valid_i while not in WAIT_ROW SHALL be ignored (not consumed); gaps in bus_valid_i only stretch WAIT_ROW.
REQ-017 When rf_we_o=0, rf_addr_o and rf_wdata_o SHALL be 0.
REQ-018 Address arithmetic SHALL be zero-extended to ADDR_WIDTH; the maximum address is MAX_DIM*MAX_DIM-1, with no wrap.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst_i=1 at a rising edge SHALL force IDLE and clear the counters, dims, and row buffer; all outputs read 0 the following cycle.
REQ-021 Reset during WAIT_ROW or WRITE SHALL abort the load: no further writes and no done_o pulse.
REQ-022 rst_i SHALL take priority over start_i and bus handshake in the same cycle.

Structure
REQ-023 Shared package SHALL hold DATA_WIDTH, BUS_WIDTH, ADDR_WIDTH, MAX_DIM defaults and the FSM state encoding, shared with the operand register file and the operand B loader.
REQ-024 One sub-module, row_serializer (row buffer plus column counter emitting element/col), is natural; the FSM and row counter stay in operand_loader.

Verification
REQ-025 n=2,m=2, rows 0x00000002_00000001 then 0x00000004_00000003 -> writes (0,1),(1,2),(2,3),(3,4) on consecutive cycles per row; done_o one cycle after write (3,4).
REQ-026 n=1,m=1, row 0xDEADBEEF_12345678 -> single write (0,0x12345678), addr 1 never written, done_o next cycle.
REQ-027 start with dim_n=0, and separately with dim_m=3 -> err_o pulse, busy_o stays 0, no rf_we_o.
REQ-028 n=2,m=1 with 5 idle cycles between rows plus start_i asserted mid-load -> writes (0,row0[31:0]),(2,row1[31:0]) only, start ignored, single done_o.
REQ-029 rst_i asserted the cycle after the first write of n=2,m=2 -> no further writes, no done_o, outputs 0, fresh start then loads correctly.
